// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses Instr_Mem and loads the IF/ID register.
// Handles stall, branch redirect, halt on a zero word, and counts retired fetches.
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;

    // Instruction memory is addressed straight from the PC register.
    assign imem_addr = pc;

    // Sequencer, PC and IF/ID register; redirect beats stall beats normal fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            if_id_pc     <= '0;
            if_id_pc4    <= '0;
            if_id_instr  <= NOP_INSTR;
            if_id_valid  <= 1'b0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            case (state)
                BOOT: begin
                    // Give Instr_Mem one cycle on the reset PC before capturing.
                    state <= RUN;
                end

                RUN: begin
                    if (branch_taken) begin
                        pc          <= branch_target & ALIGN_MASK;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        if (branch_target[1:0] != 2'b00) begin
                            misalign_err <= 1'b1;
                        end
                    end else if (stall) begin
                        // Hazard hold: nothing moves.
                    end else if (HALT_ON_ZERO && (imem_instr == '0)) begin
                        state       <= HALT;
                        halted      <= 1'b1;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                    end else begin
                        if_id_pc    <= pc;
                        if_id_pc4   <= pc + PC_STEP;
                        if_id_instr <= imem_instr;
                        if_id_valid <= 1'b1;
                        pc          <= pc + PC_STEP;
                        fetch_count <= fetch_count + XLEN'(1);
                    end
                end

                HALT: begin
                    // Only a redirect (or reset) restarts fetching.
                    if (branch_taken) begin
                        state       <= RUN;
                        halted      <= 1'b0;
                        pc          <= branch_target & ALIGN_MASK;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        if (branch_target[1:0] != 2'b00) begin
                            misalign_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table through a scoreboard queue,
// plus hand sequences for mid-cycle reset and PC wrap.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .if_id_pc     (if_id_pc),
        .if_id_pc4    (if_id_pc4),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .halted       (halted),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] instr;
        logic [31:0] e_pc;
        logic [31:0] e_ipc;
        logic [31:0] e_ipc4;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_halt;
        logic        e_mis;
        logic [31:0] e_cnt;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(logic s, logic b, logic [31:0] t, logic [31:0] i,
                                logic [31:0] pc, logic [31:0] ipc, logic [31:0] ipc4,
                                logic [31:0] ins, logic v, logic h, logic m, logic [31:0] c);
        vec_t r;
        r.stall = s;   r.br = b;       r.tgt = t;       r.instr = i;
        r.e_pc = pc;   r.e_ipc = ipc;  r.e_ipc4 = ipc4; r.e_instr = ins;
        r.e_valid = v; r.e_halt = h;   r.e_mis = m;     r.e_cnt = c;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_reset(string tag);
        chk({tag, "_pc"},    imem_addr, 32'h0);
        chk({tag, "_ipc"},   if_id_pc, 32'h0);
        chk({tag, "_ipc4"},  if_id_pc4, 32'h0);
        chk({tag, "_instr"}, if_id_instr, NOP);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'h0);
        chk({tag, "_halt"},  32'(halted), 32'h0);
        chk({tag, "_mis"},   32'(misalign_err), 32'h0);
        chk({tag, "_cnt"},   fetch_count, 32'h0);
    endtask

    // Drive one vector at negedge, queue its expectation, compare after the edge.
    task automatic run_vec(vec_t v, string tag);
        vec_t e;
        @(negedge clk);
        stall         = v.stall;
        branch_taken  = v.br;
        branch_target = v.tgt;
        imem_instr    = v.instr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty actual=0 required=1", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_pc"},    imem_addr, e.e_pc);
            chk({tag, "_ipc"},   if_id_pc, e.e_ipc);
            chk({tag, "_ipc4"},  if_id_pc4, e.e_ipc4);
            chk({tag, "_instr"}, if_id_instr, e.e_instr);
            chk({tag, "_valid"}, 32'(if_id_valid), 32'(e.e_valid));
            chk({tag, "_halt"},  32'(halted), 32'(e.e_halt));
            chk({tag, "_mis"},   32'(misalign_err), 32'(e.e_mis));
            chk({tag, "_cnt"},   fetch_count, e.e_cnt);
        end
    endtask

    initial begin
        // Boot, first two fetches (stall during BOOT must be ignored)
        vecs.push_back(mk(1, 0, 0, 32'h004081B3, 32'h0,  32'h0, 32'h0, NOP,          0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h004081B3, 32'h4,  32'h0, 32'h4, 32'h004081B3, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h401181B3, 32'h8,  32'h4, 32'h8, 32'h401181B3, 1, 0, 0, 2));
        // Three stalled cycles at pc=8
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 0, 0, 32'hAAAA0001, 32'h8, 32'h4, 32'h8, 32'h401181B3, 1, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 32'h00A00093, 32'hC,  32'h8, 32'hC, 32'h00A00093, 1, 0, 0, 3));
        // Redirect coinciding with stall
        vecs.push_back(mk(1, 1, 32'h20, 32'h12345678, 32'h20, 32'h8, 32'hC, NOP,     0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 32'h00100113, 32'h24, 32'h20, 32'h24, 32'h00100113, 1, 0, 0, 4));
        // Redirect to 0x14 then zero word halts
        vecs.push_back(mk(0, 1, 32'h14, 32'h00100113, 32'h14, 32'h20, 32'h24, NOP,   0, 0, 0, 4));
        vecs.push_back(mk(0, 0, 0, 32'h0, 32'h14, 32'h20, 32'h24, NOP,               0, 1, 0, 4));
        // Ten cycles frozen in HALT with nonzero words and toggling stall
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(logic'(i % 2), 0, 0, 32'h00000033, 32'h14, 32'h20, 32'h24, NOP, 0, 1, 0, 4));
        // Redirect out of HALT to 0
        vecs.push_back(mk(0, 1, 32'h0, 32'h00000033, 32'h0, 32'h20, 32'h24, NOP,     0, 0, 0, 4));
        vecs.push_back(mk(0, 0, 0, 32'h004081B3, 32'h4,  32'h0, 32'h4, 32'h004081B3, 1, 0, 0, 5));
        // Misaligned redirect: sticky error, aligned pc
        vecs.push_back(mk(0, 1, 32'h12, 32'h0, 32'h10,  32'h0, 32'h4, NOP,           0, 0, 1, 5));
        vecs.push_back(mk(0, 0, 0, 32'h00000093, 32'h14, 32'h10, 32'h14, 32'h00000093, 1, 0, 1, 6));
        vecs.push_back(mk(0, 1, 32'h40, 32'h0, 32'h40,  32'h10, 32'h14, NOP,         0, 0, 1, 6));
        vecs.push_back(mk(0, 0, 0, 32'h00200193, 32'h44, 32'h40, 32'h44, 32'h00200193, 1, 0, 1, 7));

        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_instr    = 32'h0;

        // Async reset from power-up
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_reset("rst0");
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst1");
        rst = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Mid-cycle reset while running: outputs clear without a clock edge
        @(negedge clk);
        stall = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset("midrst");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // PC wrap from FFFF_FFFC to 0
        run_vec(mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, NOP, 0, 0, 0, 0), "wboot");
        run_vec(mk(0, 1, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, NOP, 0, 0, 0, 0), "wredir");
        run_vec(mk(0, 0, 0, 32'h00000513, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h00000513, 1, 0, 0, 1), "wrap");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
